// File: rtl/i2s_pkg.sv
// Shared I2S constants, stereo payload type and slot-to-bit mapping,
// used by both the transmitter and the mic receiver.
package i2s_pkg;

    localparam int unsigned SAMPLE_WIDTH     = 16;
    localparam int unsigned SLOT_BITS        = 32;
    localparam int unsigned BCLK_DIV_LOG2    = 5;
    localparam int unsigned FRAME_CNT_WIDTH  = 11;
    localparam int unsigned SLOT_IDX_WIDTH   = FRAME_CNT_WIDTH - 1 - BCLK_DIV_LOG2;
    localparam int unsigned SAMPLE_IDX_WIDTH = $clog2(SAMPLE_WIDTH);

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] left;
        logic [SAMPLE_WIDTH-1:0] right;
    } stereo_t;

    // Slot 0 is the one-BCLK I2S delay; slots 1..16 carry MSB..LSB; the rest pad with 0.
    function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0]   sample,
                                      input logic [SLOT_IDX_WIDTH-1:0] slot);
        logic                        bit_val;
        logic [SAMPLE_IDX_WIDTH-1:0] idx;
        bit_val = 1'b0;
        idx     = SAMPLE_IDX_WIDTH'(SAMPLE_WIDTH - 32'(slot));
        if ((slot != '0) && (32'(slot) <= SAMPLE_WIDTH)) begin
            bit_val = sample[idx];
        end
        return bit_val;
    endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Free-running I2S frame counter with registered bit clock and word select.
// Exposes slot/half position and a frame-boundary strobe for tx or rx datapaths.
module i2s_frame_timer
    import i2s_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_in,
    output logic [SLOT_IDX_WIDTH-1:0] cnt_slot_out,
    output logic                      cnt_half_out,
    output logic                      frame_zero_c,
    output logic                      bclk_out,
    output logic                      lrclk_out
);

    logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       bclk_q, bclk_d;
    logic                       lrclk_q, lrclk_d;

    always_comb begin
        cnt_d   = cnt_q + FRAME_CNT_WIDTH'(1);
        bclk_d  = cnt_q[BCLK_DIV_LOG2-1];
        lrclk_d = cnt_q[FRAME_CNT_WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            cnt_q   <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign cnt_slot_out = cnt_q[FRAME_CNT_WIDTH-2:BCLK_DIV_LOG2];
    assign cnt_half_out = cnt_q[FRAME_CNT_WIDTH-1];
    assign frame_zero_c = (cnt_q == '0);
    assign bclk_out     = bclk_q;
    assign lrclk_out    = lrclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: single-entry holding register, per-frame active
// register and serialiser, all timed from i2s_frame_timer.
module i2s_tx
    import i2s_pkg::*;
(
    input  logic                    audio_clk,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    bclk_out,
    output logic                    lrclk_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    logic [SLOT_IDX_WIDTH-1:0] slot;
    logic                      half;
    logic                      frame_zero;
    logic                      accept;

    stereo_t hold_q, hold_d;
    stereo_t active_q, active_d;
    logic    full_q, full_d;
    logic    sdata_q, sdata_d;
    logic    frame_start_q, frame_start_d;
    logic    underrun_q, underrun_d;

    i2s_frame_timer u_timer (
        .clk          (audio_clk),
        .rst_in       (rst_in),
        .cnt_slot_out (slot),
        .cnt_half_out (half),
        .frame_zero_c (frame_zero),
        .bclk_out     (bclk_out),
        .lrclk_out    (lrclk_out)
    );

    // Ready is held low during reset so nothing is accepted into a clearing register.
    assign ready_out = !full_q && !rst_in;
    assign accept    = valid_in && ready_out;

    always_comb begin
        hold_d        = hold_q;
        full_d        = full_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (frame_zero) begin
            frame_start_d = 1'b1;
            if (full_q) begin
                active_d = hold_q;
                full_d   = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Only reachable when empty, so a boundary-cycle pair waits for the next frame.
        if (accept) begin
            hold_d.left  = left_in;
            hold_d.right = right_in;
            full_d       = 1'b1;
        end

        // Slot 0 is always 0, so a stale active_q at the frame boundary is harmless.
        sdata_d = slot_bit(half ? active_q.right : active_q.left, slot);
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            hold_q        <= '0;
            active_q      <= '0;
            full_q        <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            active_q      <= active_d;
            full_q        <= full_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sdata_out       = sdata_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx: decodes whole frames from the serial outputs
// and compares against hand-computed samples, flags and clock timing.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        valid_in;
    logic        ready_out;
    logic        bclk_out;
    logic        lrclk_out;
    logic        sdata_out;
    logic        frame_start_out;
    logic        underrun_out;

    int total = 0;
    int bad   = 0;

    logic [15:0] cap_l, cap_r;
    int n_fs, n_ur, n_bad_clk, n_bad_tog, n_bad_pad, n_bclk_rise, n_lr_rise;

    i2s_tx dut (
        .audio_clk       (clk),
        .rst_in          (rst_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .bclk_out        (bclk_out),
        .lrclk_out       (lrclk_out),
        .sdata_out       (sdata_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advances at least one cycle, then until the frame-start pulse is visible.
    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (frame_start_out !== 1'b1 && n < 4096) begin
            step();
            n++;
        end
        total++;
        if (frame_start_out !== 1'b1) begin
            bad++;
            $display("FAIL wait_frame: frame_start_out=%b required 1 within 4096 cycles", frame_start_out);
        end
    endtask

    // Decodes one 2048-cycle frame starting at the frame-start pulse (offset 0).
    task automatic capture(input bit skip_wait);
        logic        prev_sd, prev_bclk, prev_lr;
        logic [10:0] kk;
        int          slot;
        if (!skip_wait) wait_frame();
        cap_l = '0; cap_r = '0;
        n_fs = 0; n_ur = 0; n_bad_clk = 0; n_bad_tog = 0; n_bad_pad = 0;
        n_bclk_rise = 0; n_lr_rise = 0;
        prev_sd = 1'b0; prev_bclk = 1'b0; prev_lr = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            if (k > 0) step();
            kk = 11'(k);
            if (frame_start_out === 1'b1) n_fs++;
            if (underrun_out === 1'b1) n_ur++;
            if (bclk_out !== kk[4] || lrclk_out !== kk[10]) n_bad_clk++;
            if (k > 0) begin
                if (sdata_out !== prev_sd && kk[4:0] != 5'd0) n_bad_tog++;
                if (bclk_out === 1'b1 && prev_bclk === 1'b0) n_bclk_rise++;
                if (lrclk_out === 1'b1 && prev_lr === 1'b0) n_lr_rise++;
            end
            if (kk[4:0] == 5'd16) begin
                slot = int'(kk[9:5]);
                if (slot >= 1 && slot <= 16) begin
                    if (kk[10]) cap_r[4'(16 - slot)] = sdata_out;
                    else        cap_l[4'(16 - slot)] = sdata_out;
                end else if (sdata_out !== 1'b0) begin
                    n_bad_pad++;
                end
            end
            prev_sd   = sdata_out;
            prev_bclk = bclk_out;
            prev_lr   = lrclk_out;
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        left_in  = l;
        right_in = r;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b0; left_in = '0; right_in = '0;
        steps(4);
        total++;
        if ({ready_out, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {ready_out, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out});
        end
        rst_in = 1'b0;
        #1;
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after: ready_out=%b required 1", ready_out);
        end
        // First frame starts on the very next edge, with no pair held.
        step();
        total++;
        if (frame_start_out !== 1'b1 || underrun_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_frame: fs=%b ur=%b required 1 1", frame_start_out, underrun_out);
        end
        capture(1'b1);
        total++;
        if (cap_l !== 16'h0000 || cap_r !== 16'h0000 || n_bad_pad != 0) begin
            bad++;
            $display("FAIL reset_zero_frame: L=%h R=%h pad=%0d required 0000 0000 0", cap_l, cap_r, n_bad_pad);
        end
    endtask

    task automatic test_basic();
        int n_ready_hi, n;
        steps(100);
        send_pair(16'h8001, 16'h7FFE);
        total++;
        if (ready_out !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready_full: ready_out=%b required 0", ready_out);
        end
        n_ready_hi = 0;
        n = 0;
        while (frame_start_out !== 1'b1 && n < 4096) begin
            if (ready_out !== 1'b0) n_ready_hi++;
            step();
            n++;
        end
        total++;
        if (frame_start_out !== 1'b1 || n_ready_hi != 0) begin
            bad++;
            $display("FAIL basic_wait_load: fs=%b ready_high_cycles=%0d required 1 0", frame_start_out, n_ready_hi);
        end
        total++;
        if (ready_out !== 1'b1 || underrun_out !== 1'b0) begin
            bad++;
            $display("FAIL basic_load_flags: ready=%b ur=%b required 1 0", ready_out, underrun_out);
        end
        capture(1'b1);
        total++;
        if (cap_l !== 16'h8001 || cap_r !== 16'h7FFE || n_bad_pad != 0) begin
            bad++;
            $display("FAIL basic_data: L=%h R=%h pad=%0d required 8001 7ffe 0", cap_l, cap_r, n_bad_pad);
        end
    endtask

    task automatic test_underrun();
        for (int f = 0; f < 2; f++) begin
            capture(1'b0);
            total++;
            if (n_ur != 1 || n_fs != 1 || cap_l !== 16'h8001 || cap_r !== 16'h7FFE) begin
                bad++;
                $display("FAIL underrun_repeat[%0d]: ur=%0d fs=%0d L=%h R=%h required 1 1 8001 7ffe",
                         f, n_ur, n_fs, cap_l, cap_r);
            end
        end
    endtask

    task automatic test_timing();
        capture(1'b0);
        total++;
        if (n_bad_clk != 0 || n_bclk_rise != 64 || n_lr_rise != 1) begin
            bad++;
            $display("FAIL timing_clocks: bad=%0d bclk_rises=%0d lr_rises=%0d required 0 64 1",
                     n_bad_clk, n_bclk_rise, n_lr_rise);
        end
        total++;
        if (n_bad_tog != 0) begin
            bad++;
            $display("FAIL timing_sdata_toggle: off_boundary_toggles=%0d required 0", n_bad_tog);
        end
    endtask

    task automatic test_zero_accept();
        wait_frame();
        // Offset 0 shows counter==1, so 2047 cycles later the counter is 0.
        steps(2047);
        send_pair(16'hC001, 16'h0003);
        total++;
        if (frame_start_out !== 1'b1 || underrun_out !== 1'b1 || ready_out !== 1'b0) begin
            bad++;
            $display("FAIL zero_accept_flags: fs=%b ur=%b ready=%b required 1 1 0",
                     frame_start_out, underrun_out, ready_out);
        end
        capture(1'b0);
        total++;
        if (cap_l !== 16'hC001 || cap_r !== 16'h0003 || n_ur != 0) begin
            bad++;
            $display("FAIL zero_accept_next: L=%h R=%h ur=%0d required c001 0003 0", cap_l, cap_r, n_ur);
        end
    endtask

    task automatic test_full_ignore();
        int n_ready_hi, n;
        steps(300);
        send_pair(16'hA5C3, 16'h1234);
        left_in    = 16'h0F0F;
        right_in   = 16'hF0F0;
        valid_in   = 1'b1;
        n_ready_hi = 0;
        n          = 0;
        while (frame_start_out !== 1'b1 && n < 4096) begin
            if (ready_out !== 1'b0) n_ready_hi++;
            step();
            n++;
        end
        valid_in = 1'b0;
        total++;
        if (frame_start_out !== 1'b1 || n_ready_hi != 0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL full_ready: fs=%b ready_high_cycles=%0d ready_at_load=%b required 1 0 1",
                     frame_start_out, n_ready_hi, ready_out);
        end
        capture(1'b1);
        total++;
        if (cap_l !== 16'hA5C3 || cap_r !== 16'h1234 || n_ur != 0) begin
            bad++;
            $display("FAIL full_first: L=%h R=%h ur=%0d required a5c3 1234 0", cap_l, cap_r, n_ur);
        end
        capture(1'b0);
        total++;
        if (cap_l !== 16'hA5C3 || cap_r !== 16'h1234 || n_ur != 1) begin
            bad++;
            $display("FAIL full_ignored: L=%h R=%h ur=%0d required a5c3 1234 1", cap_l, cap_r, n_ur);
        end
    endtask

    task automatic test_mid_reset();
        wait_frame();
        steps(699);
        rst_in = 1'b1;
        steps(3);
        total++;
        if ({ready_out, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out} !== 6'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b required 000000",
                     {ready_out, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out});
        end
        rst_in = 1'b0;
        capture(1'b0);
        total++;
        if (cap_l !== 16'h0000 || cap_r !== 16'h0000 || n_ur != 1 || n_bad_clk != 0) begin
            bad++;
            $display("FAIL midreset_frame: L=%h R=%h ur=%0d clkbad=%0d required 0000 0000 1 0",
                     cap_l, cap_r, n_ur, n_bad_clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_timing();
        test_zero_accept();
        test_full_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
